// File: rtl/core_pkg.sv
// Shared definitions for the ARM-subset core: ALU commands, field widths, ID/EXE control bundle.
package core_pkg;

    localparam int EXE_CMD_W   = 4;
    localparam int DATA_W_D    = 32;
    localparam int SHIFT_OP_W_D = 12;
    localparam int IMM24_W_D   = 24;
    localparam int REG_IDX_W_D = 4;
    localparam int STATUS_W    = 4;

    // Several mnemonics share an ALU operation (CMP/SUB, TST/AND, LDR/STR/ADD).
    localparam logic [EXE_CMD_W-1:0] EXE_MOV = 4'b0001;
    localparam logic [EXE_CMD_W-1:0] EXE_MVN = 4'b1001;
    localparam logic [EXE_CMD_W-1:0] EXE_ADD = 4'b0010;
    localparam logic [EXE_CMD_W-1:0] EXE_ADC = 4'b0011;
    localparam logic [EXE_CMD_W-1:0] EXE_SUB = 4'b0100;
    localparam logic [EXE_CMD_W-1:0] EXE_SBC = 4'b0101;
    localparam logic [EXE_CMD_W-1:0] EXE_AND = 4'b0110;
    localparam logic [EXE_CMD_W-1:0] EXE_ORR = 4'b0111;
    localparam logic [EXE_CMD_W-1:0] EXE_EOR = 4'b1000;
    localparam logic [EXE_CMD_W-1:0] EXE_CMP = 4'b0100;
    localparam logic [EXE_CMD_W-1:0] EXE_TST = 4'b0110;
    localparam logic [EXE_CMD_W-1:0] EXE_LDR = 4'b0010;
    localparam logic [EXE_CMD_W-1:0] EXE_STR = 4'b0010;

    typedef struct packed {
        logic                 wb_en;
        logic                 mem_r_en;
        logic                 mem_w_en;
        logic                 b;
        logic                 s;
        logic [EXE_CMD_W-1:0] exe_cmd;
    } id_exe_ctrl_t;

    // Bubble: no writeback, no memory access, no branch, no status update.
    localparam id_exe_ctrl_t ID_EXE_CTRL_NOP = '0;

endpackage

// File: rtl/pipe_field_reg.sv
// Parameterised pipeline field register; update priority rst > flush > freeze > load.
module pipe_field_reg #(
    parameter int           W      = 8,
    parameter logic [W-1:0] BUBBLE = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         freeze,
    input  logic [W-1:0] d_in,
    output logic [W-1:0] q_out
);

    logic [W-1:0] field_d;
    logic [W-1:0] field_q;

    always_comb begin
        field_d = field_q;
        if (flush) begin
            field_d = BUBBLE;
        end else if (!freeze) begin
            field_d = d_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            field_q <= '0;
        end else begin
            field_q <= field_d;
        end
    end

    assign q_out = field_q;

endmodule

// File: rtl/id_exe_stage_reg.sv
// ID/EXE pipeline register with stall and flush handling.
// Define ID_EXE_FWD_EN to carry source register indices for the EXE forwarding unit.
module id_exe_stage_reg
    import core_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int SHIFT_OP_W = 12,
    parameter int IMM24_W    = 24,
    parameter int REG_IDX_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  freeze,
    input  logic [DATA_W-1:0]     pc_in,
    input  logic                  wb_en_in,
    input  logic                  mem_r_en_in,
    input  logic                  mem_w_en_in,
    input  logic [3:0]            exe_cmd_in,
    input  logic                  b_in,
    input  logic                  s_in,
    input  logic                  imm_in,
    input  logic [DATA_W-1:0]     val_rn_in,
    input  logic [DATA_W-1:0]     val_rm_in,
    input  logic [SHIFT_OP_W-1:0] shift_operand_in,
    input  logic [IMM24_W-1:0]    signed_imm_24_in,
    input  logic [REG_IDX_W-1:0]  dest_in,
    input  logic [3:0]            status_in,
`ifdef ID_EXE_FWD_EN
    input  logic [REG_IDX_W-1:0]  src1_in,
    input  logic [REG_IDX_W-1:0]  src2_in,
    input  logic                  src2_used_in,
    output logic [REG_IDX_W-1:0]  src1_out,
    output logic [REG_IDX_W-1:0]  src2_out,
    output logic                  src2_used_out,
`endif
    output logic [DATA_W-1:0]     pc_out,
    output logic                  wb_en_out,
    output logic                  mem_r_en_out,
    output logic                  mem_w_en_out,
    output logic [3:0]            exe_cmd_out,
    output logic                  b_out,
    output logic                  s_out,
    output logic                  imm_out,
    output logic [DATA_W-1:0]     val_rn_out,
    output logic [DATA_W-1:0]     val_rm_out,
    output logic [SHIFT_OP_W-1:0] shift_operand_out,
    output logic [IMM24_W-1:0]    signed_imm_24_out,
    output logic [REG_IDX_W-1:0]  dest_out,
    output logic [3:0]            status_out,
    output logic                  val2_sel_out,
    output logic                  valid_out
);

    localparam int CTRL_W = $bits(id_exe_ctrl_t) + 2;
    localparam int OPND_W = 2 * DATA_W + SHIFT_OP_W + 1 + REG_IDX_W + 4;
    localparam int BR_W   = DATA_W + IMM24_W;

    id_exe_ctrl_t      ctrl_in;
    id_exe_ctrl_t      ctrl_out;
    logic [CTRL_W-1:0] ctrl_d;
    logic [CTRL_W-1:0] ctrl_q;
    logic [OPND_W-1:0] opnd_d;
    logic [OPND_W-1:0] opnd_q;
    logic [BR_W-1:0]   br_d;
    logic [BR_W-1:0]   br_q;

    always_comb begin
        ctrl_in          = ID_EXE_CTRL_NOP;
        ctrl_in.wb_en    = wb_en_in;
        ctrl_in.mem_r_en = mem_r_en_in;
        ctrl_in.mem_w_en = mem_w_en_in;
        ctrl_in.b        = b_in;
        ctrl_in.s        = s_in;
        ctrl_in.exe_cmd  = exe_cmd_in;
        // Memory select is precomputed here so EXE sees it straight from a flop.
        ctrl_d = {ctrl_in, mem_r_en_in | mem_w_en_in, 1'b1};
        opnd_d = {val_rn_in, val_rm_in, shift_operand_in, imm_in, dest_in, status_in};
        br_d   = {pc_in, signed_imm_24_in};
    end

    pipe_field_reg #(.W(CTRL_W), .BUBBLE({ID_EXE_CTRL_NOP, 2'b00})) u_ctrl_reg (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush),
        .freeze (freeze),
        .d_in   (ctrl_d),
        .q_out  (ctrl_q)
    );

    pipe_field_reg #(.W(OPND_W)) u_opnd_reg (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush),
        .freeze (freeze),
        .d_in   (opnd_d),
        .q_out  (opnd_q)
    );

    pipe_field_reg #(.W(BR_W)) u_br_reg (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush),
        .freeze (freeze),
        .d_in   (br_d),
        .q_out  (br_q)
    );

    assign {ctrl_out, val2_sel_out, valid_out} = ctrl_q;
    assign wb_en_out    = ctrl_out.wb_en;
    assign mem_r_en_out = ctrl_out.mem_r_en;
    assign mem_w_en_out = ctrl_out.mem_w_en;
    assign b_out        = ctrl_out.b;
    assign s_out        = ctrl_out.s;
    assign exe_cmd_out  = ctrl_out.exe_cmd;
    assign {val_rn_out, val_rm_out, shift_operand_out, imm_out, dest_out, status_out} = opnd_q;
    assign {pc_out, signed_imm_24_out} = br_q;

`ifdef ID_EXE_FWD_EN
    localparam int FWD_W = 2 * REG_IDX_W + 1;

    logic [FWD_W-1:0] fwd_d;
    logic [FWD_W-1:0] fwd_q;

    assign fwd_d = {src1_in, src2_in, src2_used_in};

    pipe_field_reg #(.W(FWD_W)) u_fwd_reg (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush),
        .freeze (freeze),
        .d_in   (fwd_d),
        .q_out  (fwd_q)
    );

    assign {src1_out, src2_out, src2_used_out} = fwd_q;
`endif

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// Directed-vector bench for id_exe_stage_reg; define ID_EXE_FWD_EN to cover the forwarding fields.
module tb_id_exe_stage_reg;

    typedef struct {
        logic [31:0] pc;
        logic        wb, mr, mw;
        logic [3:0]  cmd;
        logic        b, s, imm;
        logic [31:0] rn, rm;
        logic [11:0] shop;
        logic [23:0] imm24;
        logic [3:0]  dest, status, src1, src2;
        logic        used;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, flush, freeze;
    logic [31:0] pc_in, val_rn_in, val_rm_in;
    logic        wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in;
    logic [3:0]  exe_cmd_in, dest_in, status_in;
    logic [11:0] shift_operand_in;
    logic [23:0] signed_imm_24_in;
    logic [3:0]  src1_in, src2_in;
    logic        src2_used_in;
    logic [31:0] pc_out, val_rn_out, val_rm_out;
    logic        wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, imm_out;
    logic [3:0]  exe_cmd_out, dest_out, status_out;
    logic [11:0] shift_operand_out;
    logic [23:0] signed_imm_24_out;
    logic        val2_sel_out, valid_out;
`ifdef ID_EXE_FWD_EN
    logic [3:0]  src1_out, src2_out;
    logic        src2_used_out;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_exe_stage_reg dut (
        .clk               (clk),
        .rst               (rst),
        .flush             (flush),
        .freeze            (freeze),
        .pc_in             (pc_in),
        .wb_en_in          (wb_en_in),
        .mem_r_en_in       (mem_r_en_in),
        .mem_w_en_in       (mem_w_en_in),
        .exe_cmd_in        (exe_cmd_in),
        .b_in              (b_in),
        .s_in              (s_in),
        .imm_in            (imm_in),
        .val_rn_in         (val_rn_in),
        .val_rm_in         (val_rm_in),
        .shift_operand_in  (shift_operand_in),
        .signed_imm_24_in  (signed_imm_24_in),
        .dest_in           (dest_in),
        .status_in         (status_in),
`ifdef ID_EXE_FWD_EN
        .src1_in           (src1_in),
        .src2_in           (src2_in),
        .src2_used_in      (src2_used_in),
        .src1_out          (src1_out),
        .src2_out          (src2_out),
        .src2_used_out     (src2_used_out),
`endif
        .pc_out            (pc_out),
        .wb_en_out         (wb_en_out),
        .mem_r_en_out      (mem_r_en_out),
        .mem_w_en_out      (mem_w_en_out),
        .exe_cmd_out       (exe_cmd_out),
        .b_out             (b_out),
        .s_out             (s_out),
        .imm_out           (imm_out),
        .val_rn_out        (val_rn_out),
        .val_rm_out        (val_rm_out),
        .shift_operand_out (shift_operand_out),
        .signed_imm_24_out (signed_imm_24_out),
        .dest_out          (dest_out),
        .status_out        (status_out),
        .val2_sel_out      (val2_sel_out),
        .valid_out         (valid_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        pc_in = v.pc; wb_en_in = v.wb; mem_r_en_in = v.mr; mem_w_en_in = v.mw;
        exe_cmd_in = v.cmd; b_in = v.b; s_in = v.s; imm_in = v.imm;
        val_rn_in = v.rn; val_rm_in = v.rm; shift_operand_in = v.shop;
        signed_imm_24_in = v.imm24; dest_in = v.dest; status_in = v.status;
        src1_in = v.src1; src2_in = v.src2; src2_used_in = v.used;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_vec(input string tag, input vec_t v, input logic vld, input logic sel);
        check({tag, ".pc"},     pc_out,            v.pc);
        check({tag, ".wb"},     {31'd0, wb_en_out},    {31'd0, v.wb});
        check({tag, ".mr"},     {31'd0, mem_r_en_out}, {31'd0, v.mr});
        check({tag, ".mw"},     {31'd0, mem_w_en_out}, {31'd0, v.mw});
        check({tag, ".cmd"},    {28'd0, exe_cmd_out},  {28'd0, v.cmd});
        check({tag, ".b"},      {31'd0, b_out},        {31'd0, v.b});
        check({tag, ".s"},      {31'd0, s_out},        {31'd0, v.s});
        check({tag, ".imm"},    {31'd0, imm_out},      {31'd0, v.imm});
        check({tag, ".rn"},     val_rn_out,        v.rn);
        check({tag, ".rm"},     val_rm_out,        v.rm);
        check({tag, ".shop"},   {20'd0, shift_operand_out}, {20'd0, v.shop});
        check({tag, ".imm24"},  {8'd0, signed_imm_24_out},  {8'd0, v.imm24});
        check({tag, ".dest"},   {28'd0, dest_out},     {28'd0, v.dest});
        check({tag, ".status"}, {28'd0, status_out},   {28'd0, v.status});
        check({tag, ".valid"},  {31'd0, valid_out},    {31'd0, vld});
        check({tag, ".val2sel"}, {31'd0, val2_sel_out}, {31'd0, sel});
`ifdef ID_EXE_FWD_EN
        check({tag, ".src1"},   {28'd0, src1_out},     {28'd0, v.src1});
        check({tag, ".src2"},   {28'd0, src2_out},     {28'd0, v.src2});
        check({tag, ".used"},   {31'd0, src2_used_out}, {31'd0, v.used});
`endif
    endtask

    vec_t vz, v0, v1, v2, v3, v4;

    initial begin
        vz = '{pc: 32'h0, wb: 0, mr: 0, mw: 0, cmd: 4'h0, b: 0, s: 0, imm: 0,
               rn: 32'h0, rm: 32'h0, shop: 12'h0, imm24: 24'h0, dest: 4'h0,
               status: 4'h0, src1: 4'h0, src2: 4'h0, used: 0};
        v0 = '{pc: 32'h1234_5678, wb: 1, mr: 1, mw: 1, cmd: 4'hF, b: 1, s: 1, imm: 1,
               rn: 32'hA5A5_A5A5, rm: 32'h5A5A_5A5A, shop: 12'hFFF, imm24: 24'hFF_FFFF,
               dest: 4'hF, status: 4'hF, src1: 4'hF, src2: 4'hF, used: 1};
        v1 = '{pc: 32'h0000_0010, wb: 1, mr: 0, mw: 0, cmd: 4'b0010, b: 0, s: 1, imm: 1,
               rn: 32'h1111_2222, rm: 32'hDEAD_BEEF, shop: 12'h0A3, imm24: 24'h00_0100,
               dest: 4'h3, status: 4'b0010, src1: 4'd3, src2: 4'd7, used: 1};
        v2 = '{pc: 32'h0000_0020, wb: 0, mr: 1, mw: 0, cmd: 4'b0010, b: 1, s: 0, imm: 0,
               rn: 32'h3333_4444, rm: 32'hCAFE_F00D, shop: 12'h555, imm24: 24'hFF_FFFE,
               dest: 4'h9, status: 4'b1000, src1: 4'd5, src2: 4'd2, used: 0};
        v3 = '{pc: 32'h0000_0030, wb: 0, mr: 0, mw: 1, cmd: 4'b0010, b: 0, s: 0, imm: 1,
               rn: 32'h0000_1000, rm: 32'h0000_00AA, shop: 12'hFFC, imm24: 24'h00_0000,
               dest: 4'h1, status: 4'b0100, src1: 4'd1, src2: 4'd4, used: 1};
        v4 = '{pc: 32'h0000_0034, wb: 1, mr: 0, mw: 0, cmd: 4'b0111, b: 0, s: 1, imm: 0,
               rn: 32'h0F0F_0F0F, rm: 32'hF0F0_F0F0, shop: 12'h801, imm24: 24'h12_3456,
               dest: 4'hC, status: 4'b0001, src1: 4'd12, src2: 4'd13, used: 1};

        rst = 1'b1; flush = 1'b1; freeze = 1'b1;
        apply(v0);
        step();
        expect_vec("reset", vz, 1'b0, 1'b0);

        rst = 1'b0; flush = 1'b0; freeze = 1'b0;
        apply(v1);
        step();
        expect_vec("load", v1, 1'b1, 1'b0);

        apply(v2);
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_vec("freeze", v1, 1'b1, 1'b0);
        end
        freeze = 1'b0;
        step();
        expect_vec("release", v2, 1'b1, 1'b1);

        freeze = 1'b1; flush = 1'b1;
        step();
        expect_vec("flush_frz", vz, 1'b0, 1'b0);
        freeze = 1'b0;
        step();
        expect_vec("flush2", vz, 1'b0, 1'b0);

        flush = 1'b0;
        apply(v3);
        step();
        expect_vec("memsel_w", v3, 1'b1, 1'b1);
        apply(v4);
        step();
        expect_vec("memsel_0", v4, 1'b1, 1'b0);

        apply(v1);
        freeze = 1'b1; rst = 1'b1;
        step();
        expect_vec("rst_stall", vz, 1'b0, 1'b0);
        rst = 1'b0;
        step();
        expect_vec("stall_hold0", vz, 1'b0, 1'b0);
        freeze = 1'b0;
        step();
        expect_vec("resume", v1, 1'b1, 1'b0);

        flush = 1'b1;
        step();
        expect_vec("flush_run", vz, 1'b0, 1'b0);
        flush = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_exe_stage_reg.md
Name: id_exe_stage_reg

Overview:
- ID/EXE pipeline register of the ARM-subset 5-stage core.
- Captures decoded control fields and operands from the ID stage each cycle.
- Presents them to the EXE stage: ALU, Val2 generator (Rm value, imm flag, 12-bit shift operand, mem-select), branch adder and status logic.
- Implements stall (freeze) and flush (branch bubble) handling with defined priority.

Parameters:
- DATA_W, 32, width of PC and register operands.
- SHIFT_OP_W, 12, width of shifter_operand field.
- IMM24_W, 24, width of branch signed_imm_24 field.
- REG_IDX_W, 4, register index width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- flush  in  1  branch-taken flush; insert bubble
- freeze  in  1  hazard stall; hold contents
- pc_in  in  DATA_W  PC+4 of instruction in ID
- wb_en_in  in  1  writeback enable
- mem_r_en_in  in  1  load
- mem_w_en_in  in  1  store
- exe_cmd_in  in  4  ALU command
- b_in  in  1  branch
- s_in  in  1  update status
- imm_in  in  1  I bit
- val_rn_in  in  DATA_W  Rn value
- val_rm_in  in  DATA_W  Rm value
- shift_operand_in  in  SHIFT_OP_W  shifter operand
- signed_imm_24_in  in  IMM24_W  branch offset
- dest_in  in  REG_IDX_W  destination register
- status_in  in  4  NZCV at decode time (for carry-in)
- Outputs: same names with _out suffix, registered, widths identical to the inputs.
- val2_sel_out  out  1  registered (mem_r_en_in | mem_w_en_in); drives the Val2 generator memory select
- valid_out  out  1  stage holds a real instruction

Behaviour:
- Latency 1 cycle; all outputs are direct flop outputs, no combinational input-to-output path.
- Update priority each rising edge: rst > flush > freeze > load.
- rst=1: every output 0, including valid_out and val2_sel_out.
- flush=1, rst=0: every output 0 and valid_out=0. This is a bubble.
  - flush overrides freeze: a branch resolved while stalled still kills the instruction.
- freeze=1, flush=0: every output holds its previous value, including valid_out.
- Otherwise: every field loads its _in value.
  - valid_out=1.
  - val2_sel_out = mem_r_en_in | mem_w_en_in.
- A bubble must have wb_en_out=mem_r_en_out=mem_w_en_out=b_out=s_out=0, so no architectural side effect downstream.
- Reset or flush asserted mid-stall clears the stage on that edge. After deassertion, loading resumes on the first edge with freeze=0.
- Consecutive flushes produce consecutive bubbles.
- Held or bubbled values must not glitch between edges.

Optional Feature:
- Macro ID_EXE_FWD_EN.
- Defined:
  - Adds inputs src1_in, src2_in (REG_IDX_W), outputs src1_out, src2_out, and input src2_used_in with output src2_used_out.
  - These follow identical rst/flush/freeze/load rules; bubble values are 0.
  - The forwarding unit in EXE consumes them.
- Undefined: these ports and flops do not exist; all other behaviour is identical.

Decomposition:
- Shared package core_pkg holds:
  - EXE_CMD_W=4.
  - ALU command constants (MOV, MVN, ADD, ADC, SUB, SBC, AND, ORR, EOR, CMP, TST, LDR, STR).
  - Field widths.
  - A packed struct id_exe_ctrl_t {wb_en, mem_r_en, mem_w_en, b, s, exe_cmd} so the bubble value is a single constant, ID_EXE_CTRL_NOP.
- One natural sub-module, pipe_field_reg: a parameterised-width register with rst/flush/freeze/load priority. It is instantiated per field group (control, operands, branch, fwd).

Test Plan:
- Reset: drive all inputs nonzero, rst=1 one edge → every output 0, valid_out=0.
- Load: pc_in=0x0000_0010, exe_cmd_in=4'b0010, val_rm_in=0xDEAD_BEEF, shift_operand_in=0x0A3, imm_in=1, wb_en_in=1 → next edge outputs equal inputs, valid_out=1, val2_sel_out=0.
- Freeze: after the load, change every input and hold freeze=1 for 3 edges → outputs keep 0x0000_0010 / 0xDEAD_BEEF etc.; release → new values appear one edge later.
- Flush during freeze: freeze=1 and flush=1 together with a valid instruction held → next edge all outputs 0, valid_out=0; wb_en_out=0, mem_w_en_out=0.
- Memory select: mem_w_en_in=1, shift_operand_in=0xFFC → val2_sel_out=1, shift_operand_out=0xFFC. Next load with mem_r_en_in=mem_w_en_in=0 → val2_sel_out=0.
- Build with ID_EXE_FWD_EN: src1_in=4'd3, src2_in=4'd7 → outputs 3/7 after one edge; flush → both 0.
